mp_ctrl: RTL and testbench



---
 rtl/mp_pkg.sv | 37 +++
 rtl/mp_wdt.sv | 29 ++
 rtl/mp_ctrl.sv | 204 ++++++++++++++++++++
 tb/tb_mp_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mp_pkg.sv
// Shared encodings for the multiplier sequencer, its write-data mux and the register file.
package mp_pkg;

  typedef enum logic [3:0] {
    ST_INIT     = 4'h0,
    ST_OP_READ  = 4'h1,
    ST_OP_WAIT1 = 4'h2,
    ST_RA_READ  = 4'h3,
    ST_RB_READ  = 4'h4,
    ST_OP_WAIT2 = 4'h5,
    ST_OP_CAL   = 4'h6,
    ST_SELECT   = 4'h7,
    ST_RESULT   = 4'h8
  } state_e;

  localparam logic [3:0] REG_DATA   = 4'h0;
  localparam logic [3:0] REG_INST   = 4'h1;
  localparam logic [3:0] REG_CONT   = 4'h2;
  localparam logic [3:0] REG_RESULT = 4'h3;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_MUL = 4'h1;

  localparam logic [7:0] STATUS_ADDR = 8'h20;

  typedef struct packed {
    logic [3:0] op;
    logic [3:0] rd;
    logic [3:0] ra;
    logic [3:0] rb;
  } inst_t;

  function automatic logic [7:0] reg_addr(input logic [3:0] region, input logic [3:0] idx);
    return {region, idx};
  endfunction

endpackage

// File: rtl/mp_wdt.sv
// Multiplier watchdog: counts busy cycles and flags expiry on the LIMIT-th one.
module mp_wdt #(
  parameter int unsigned LIMIT = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic clear_i,
  input  logic enable_i,
  output logic expire_o
);

  localparam int unsigned CNT_W = $clog2(LIMIT) + 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i)       cnt_d = '0;
    else if (enable_i) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign expire_o = enable_i && (cnt_q == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/mp_ctrl.sv
// Sequencing FSM for the multiplier: fetches instructions, reads operands, writes products.
// Define MP_TIMEOUT_EN to add the mp_wdt watchdog that aborts a stalled multiply.
module mp_ctrl
  import mp_pkg::*;
#(
  parameter int unsigned INST_DEPTH  = 16,
  parameter int unsigned PC_W        = 4,
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            s_sel,
  input  logic            s_wr,
  input  logic [15:0]     s_addr,
  input  logic [31:0]     s_din,
  input  logic [63:0]     r_data,
  input  logic            mul_done,
  input  logic [63:0]     mul_result,
  output logic [3:0]      cur_state,
  output logic            r_en,
  output logic [7:0]      r_addr,
  output logic            w_en,
  output logic [7:0]      w_addr,
  output logic            mul_start,
  output logic [31:0]     mul_op_a,
  output logic [31:0]     mul_op_b,
  output logic [63:0]     to_Rd,
  output logic [PC_W-1:0] pc,
  output logic            interrupt,
  output logic            err
);

  localparam logic [PC_W-1:0] PC_LAST = PC_W'(INST_DEPTH - 1);

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  inst_t           inst_q, inst_d;
  logic [31:0]     op_a_q, op_a_d;
  logic [31:0]     op_b_q, op_b_d;
  logic [63:0]     to_rd_q, to_rd_d;
  logic            mul_start_q, mul_start_d;
  logic            irq_q, irq_d;
  logic            err_q, err_d;

  logic            host_wr;
  logic            start_cmd;
  logic            done_ok;
  logic            wdt_expire;
  inst_t           fetched;
  logic            unused_bits;

  assign host_wr   = s_sel & s_wr;
  assign start_cmd = host_wr && (s_addr[7:4] == REG_CONT) && s_din[0];
  // A done pulse coinciding with our own start pulse belongs to a previous operation.
  assign done_ok   = mul_done & ~mul_start_q;
  assign fetched   = inst_t'(r_data[15:0]);

  assign unused_bits = ^{s_addr[15:8], s_din[31:1], r_data[63:32]};

`ifdef MP_TIMEOUT_EN
  logic wdt_clear;
  logic wdt_enable;

  assign wdt_clear  = (state_q == ST_OP_WAIT2);
  assign wdt_enable = (state_q == ST_OP_CAL);

  mp_wdt #(
    .LIMIT (TIMEOUT_CYC)
  ) u_wdt (
    .clk      (clk),
    .reset    (reset),
    .clear_i  (wdt_clear),
    .enable_i (wdt_enable),
    .expire_o (wdt_expire)
  );
`else
  localparam int unsigned unused_timeout = TIMEOUT_CYC;
  assign wdt_expire = 1'b0;
`endif

  // NOTE: every combinational output and next-state value gets a default first, so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    inst_d      = inst_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    to_rd_d     = to_rd_q;
    mul_start_d = 1'b0;
    irq_d       = irq_q;
    err_d       = err_q;
    r_en        = 1'b0;
    r_addr      = 8'h00;
    w_en        = 1'b0;
    w_addr      = 8'h00;

    case (state_q)
      ST_INIT: begin
        w_en   = host_wr;
        w_addr = s_addr[7:0];
        if (start_cmd) begin
          pc_d    = '0;
          irq_d   = 1'b0;
          err_d   = 1'b0;
          state_d = ST_OP_READ;
        end
      end
      ST_OP_READ: begin
        r_en    = 1'b1;
        r_addr  = reg_addr(REG_INST, 4'(pc_q));
        state_d = ST_OP_WAIT1;
      end
      ST_OP_WAIT1: begin
        inst_d = fetched;
        if (fetched.op == OP_NOP) begin
          state_d = ST_RESULT;
        end else if (fetched.op == OP_MUL) begin
          state_d = ST_RA_READ;
        end else begin
          to_rd_d = '0;
          state_d = ST_SELECT;
        end
      end
      ST_RA_READ: begin
        r_en    = 1'b1;
        r_addr  = reg_addr(REG_DATA, inst_q.ra);
        state_d = ST_RB_READ;
      end
      ST_RB_READ: begin
        op_a_d  = r_data[31:0];
        r_en    = 1'b1;
        r_addr  = reg_addr(REG_DATA, inst_q.rb);
        state_d = ST_OP_WAIT2;
      end
      ST_OP_WAIT2: begin
        op_b_d      = r_data[31:0];
        mul_start_d = 1'b1;
        state_d     = ST_OP_CAL;
      end
      ST_OP_CAL: begin
        if (done_ok) begin
          to_rd_d = mul_result;
          state_d = ST_SELECT;
        end else if (wdt_expire) begin
          err_d   = 1'b1;
          to_rd_d = '1;
          state_d = ST_RESULT;
        end
      end
      ST_SELECT: begin
        w_en   = 1'b1;
        w_addr = reg_addr(REG_RESULT, inst_q.rd);
        if (pc_q == PC_LAST) begin
          state_d = ST_RESULT;
        end else begin
          pc_d    = pc_q + PC_W'(1);
          state_d = ST_OP_READ;
        end
      end
      ST_RESULT: begin
        w_en    = 1'b1;
        w_addr  = STATUS_ADDR;
        irq_d   = 1'b1;
        state_d = ST_INIT;
      end
      default: state_d = ST_INIT;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update from the same pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_INIT;
      pc_q        <= '0;
      inst_q      <= '0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      to_rd_q     <= '0;
      mul_start_q <= 1'b0;
      irq_q       <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      inst_q      <= inst_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      to_rd_q     <= to_rd_d;
      mul_start_q <= mul_start_d;
      irq_q       <= irq_d;
      err_q       <= err_d;
    end
  end

  assign cur_state = state_q;
  assign pc        = pc_q;
  assign mul_start = mul_start_q;
  assign mul_op_a  = op_a_q;
  assign mul_op_b  = op_b_q;
  assign to_Rd     = to_rd_q;
  assign interrupt = irq_q;
  assign err       = err_q;

endmodule

// File: tb/tb_mp_ctrl.sv
// Scoreboard bench for mp_ctrl: models the register file and multiplier, checks every FSM write.
module tb_mp_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        s_sel, s_wr;
  logic [15:0] s_addr;
  logic [31:0] s_din;
  logic [63:0] r_data;
  logic        mul_done;
  logic [63:0] mul_result;
  logic [3:0]  cur_state;
  logic        r_en, w_en, mul_start, interrupt, err;
  logic [7:0]  r_addr, w_addr;
  logic [31:0] mul_op_a, mul_op_b;
  logic [63:0] to_Rd;
  logic [3:0]  pc;

  typedef struct {
    logic [7:0]  addr;
    logic [63:0] data;
    logic        chk_data;
    logic [3:0]  pc;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] data_mem[16];
  logic [15:0] inst_mem[16];
  int          n_checks = 0;
  int          n_errors = 0;
  bit          mul_en = 1'b1;
  int          mul_lat = 2;
  int          fetch_cnt = 0;

  mp_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .s_sel      (s_sel),
    .s_wr       (s_wr),
    .s_addr     (s_addr),
    .s_din      (s_din),
    .r_data     (r_data),
    .mul_done   (mul_done),
    .mul_result (mul_result),
    .cur_state  (cur_state),
    .r_en       (r_en),
    .r_addr     (r_addr),
    .w_en       (w_en),
    .w_addr     (w_addr),
    .mul_start  (mul_start),
    .mul_op_a   (mul_op_a),
    .mul_op_b   (mul_op_b),
    .to_Rd      (to_Rd),
    .pc         (pc),
    .interrupt  (interrupt),
    .err        (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Register file: data presented the cycle after r_en, with junk in the unused upper bits.
  initial begin
    logic       en;
    logic [7:0] addr;
    r_data = '0;
    forever begin
      @(negedge clk);
      en   = r_en;
      addr = r_addr;
      @(posedge clk);
      #1;
      if (en && addr[7:4] == 4'h1) r_data = {48'hA5A5_5A5A_0000, inst_mem[addr[3:0]]};
      else if (en)                 r_data = {32'hDEAD_BEEF, data_mem[addr[3:0]]};
      else                         r_data = 64'h0;
    end
  end

  // Multiplier: done pulse mul_lat cycles after the start pulse was seen.
  initial begin
    logic [31:0] a, b;
    mul_done   = 1'b0;
    mul_result = 64'h0;
    forever begin
      @(negedge clk);
      if (mul_start && mul_en) begin
        a = mul_op_a;
        b = mul_op_b;
        repeat (mul_lat - 1) @(negedge clk);
        mul_result = {32'h0, a} * {32'h0, b};
        mul_done   = 1'b1;
        @(negedge clk);
        mul_done   = 1'b0;
        mul_result = 64'h0;
      end
    end
  end

  // Monitor: every FSM-driven write is popped against the scoreboard.
  initial begin
    exp_t e;
    int   ms_w;
    ms_w = 0;
    forever begin
      @(negedge clk);
      if (!reset && w_en && cur_state != 4'h0) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_write: w_addr=%h state=%h with nothing expected", w_addr, cur_state);
        end else begin
          e = sb_q.pop_front();
          check("w_addr", {56'h0, w_addr}, {56'h0, e.addr});
          if (e.chk_data) begin
            check("to_Rd", to_Rd, e.data);
            check("select_pc", {60'h0, pc}, {60'h0, e.pc});
          end
        end
      end
      if (r_en && r_addr[7:4] == 4'h1) fetch_cnt++;
      if (mul_start) ms_w++;
      else if (ms_w != 0) begin
        check("mul_start_width", 64'(ms_w), 64'd1);
        ms_w = 0;
      end
    end
  end

  task automatic host_write(input logic [15:0] addr, input logic [31:0] din, input bit exp_wen);
    @(negedge clk);
    s_sel  = 1'b1;
    s_wr   = 1'b1;
    s_addr = addr;
    s_din  = din;
    #1;
    check("host_w_en", {63'h0, w_en}, {63'h0, exp_wen});
    if (exp_wen) begin
      check("host_w_addr", {56'h0, w_addr}, {56'h0, addr[7:0]});
      if (addr[7:4] == 4'h0) data_mem[addr[3:0]] = din;
      if (addr[7:4] == 4'h1) inst_mem[addr[3:0]] = din[15:0];
    end
    @(negedge clk);
    s_sel  = 1'b0;
    s_wr   = 1'b0;
    s_addr = '0;
    s_din  = '0;
  endtask

  task automatic push_exp(input logic [7:0] addr, input logic [63:0] data, input logic chk, input logic [3:0] p);
    exp_t e;
    e.addr     = addr;
    e.data     = data;
    e.chk_data = chk;
    e.pc       = p;
    sb_q.push_back(e);
  endtask

  task automatic wait_irq(input int budget, input string name);
    int n;
    n = 0;
    while (!interrupt && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, {63'h0, interrupt}, 64'd1);
  endtask

  task automatic wait_state(input logic [3:0] st, input int budget, input string name);
    int n;
    n = 0;
    while (cur_state != st && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, {60'h0, cur_state}, {60'h0, st});
  endtask

  initial begin
    int n;
    reset  = 1'b1;
    s_sel  = 1'b0;
    s_wr   = 1'b0;
    s_addr = '0;
    s_din  = '0;
    for (int i = 0; i < 16; i++) begin
      data_mem[i] = '0;
      inst_mem[i] = '0;
    end

    // Reset values
    repeat (2) @(negedge clk);
    check("rst_state", {60'h0, cur_state}, 64'h0);
    check("rst_pc", {60'h0, pc}, 64'h0);
    check("rst_irq", {63'h0, interrupt}, 64'h0);
    check("rst_err", {63'h0, err}, 64'h0);
    check("rst_mul_start", {63'h0, mul_start}, 64'h0);
    check("rst_r_en", {63'h0, r_en}, 64'h0);
    check("rst_w_en", {63'h0, w_en}, 64'h0);
    check("rst_to_Rd", to_Rd, 64'h0);
    reset = 1'b0;

    // Basic multiply: Rd=3, DATA[1]*DATA[2] = 3*5
    host_write(16'h0001, 32'd3, 1'b1);
    host_write(16'h0002, 32'd5, 1'b1);
    host_write(16'h0010, 32'h1312, 1'b1);
    host_write(16'h0011, 32'h0000, 1'b1);
    push_exp(8'h33, 64'd15, 1'b1, 4'd0);
    push_exp(8'h20, 64'd0, 1'b0, 4'd0);
    fetch_cnt = 0;
    host_write(16'h0020, 32'h1, 1'b1);
    wait_irq(60, "basic_irq");
    check("basic_state", {60'h0, cur_state}, 64'h0);
    check("basic_op_a", {32'h0, mul_op_a}, 64'd3);
    check("basic_op_b", {32'h0, mul_op_b}, 64'd5);
    check("basic_err", {63'h0, err}, 64'h0);
    check("basic_fetches", 64'(fetch_cnt), 64'd2);
    check("basic_sb_drained", 64'(sb_q.size()), 64'd0);

    // Unknown opcode writes zero to Rd=4
    host_write(16'h0010, 32'h5400, 1'b1);
    push_exp(8'h34, 64'd0, 1'b1, 4'd0);
    push_exp(8'h20, 64'd0, 1'b0, 4'd0);
    host_write(16'h0020, 32'h1, 1'b1);
    wait_irq(60, "unk_irq");
    check("unk_sb_drained", 64'(sb_q.size()), 64'd0);

    // Full program: slot i computes DATA[0]*DATA[i] into RESULT[0]
    host_write(16'h0000, 32'd7, 1'b1);
    for (int i = 1; i < 16; i++) host_write(16'h0000 | 16'(i), 32'(3 * i + 1), 1'b1);
    for (int i = 0; i < 16; i++) host_write(16'h0010 | 16'(i), 32'h1000 | 32'(i), 1'b1);
    for (int i = 0; i < 16; i++)
      push_exp(8'h30, {32'h0, data_mem[0]} * {32'h0, data_mem[i]}, 1'b1, 4'(i));
    push_exp(8'h20, 64'd0, 1'b0, 4'd0);
    fetch_cnt = 0;
    host_write(16'h0020, 32'h1, 1'b1);
    wait_irq(400, "full_irq");
    check("full_fetches", 64'(fetch_cnt), 64'd16);
    check("full_pc", {60'h0, pc}, 64'd15);
    check("full_sb_drained", 64'(sb_q.size()), 64'd0);

    // Host write ignored in OP_CAL, then reset aborts the operation
    mul_en = 1'b0;
    host_write(16'h0010, 32'h1312, 1'b1);
    host_write(16'h0011, 32'h0000, 1'b1);
    host_write(16'h0020, 32'h1, 1'b1);
    wait_state(4'h6, 20, "reach_op_cal");
    host_write(16'h0020, 32'h1, 1'b0);
    check("hold_state", {60'h0, cur_state}, 64'h6);
    repeat (3) @(negedge clk);
    check("hold_state_later", {60'h0, cur_state}, 64'h6);
    reset = 1'b1;
    #1;
    check("abort_state", {60'h0, cur_state}, 64'h0);
    check("abort_to_Rd", to_Rd, 64'h0);
    check("abort_op_a", {32'h0, mul_op_a}, 64'h0);
    check("abort_op_b", {32'h0, mul_op_b}, 64'h0);
    check("abort_r_en", {63'h0, r_en}, 64'h0);
    check("abort_w_en", {63'h0, w_en}, 64'h0);
    check("abort_pc", {60'h0, pc}, 64'h0);
    @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    check("abort_idle", {60'h0, cur_state}, 64'h0);

    // Stalled multiplier
`ifdef MP_TIMEOUT_EN
    push_exp(8'h20, 64'd0, 1'b0, 4'd0);
    host_write(16'h0020, 32'h1, 1'b1);
    wait_state(4'h6, 20, "to_reach_op_cal");
    n = 0;
    while (cur_state == 4'h6 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("to_op_cal_cycles", 64'(n), 64'd64);
    wait_irq(10, "to_irq");
    check("to_err", {63'h0, err}, 64'd1);
    check("to_to_Rd", to_Rd, 64'hFFFF_FFFF_FFFF_FFFF);
    check("to_sb_drained", 64'(sb_q.size()), 64'd0);
`else
    n = 0;
    host_write(16'h0020, 32'h1, 1'b1);
    wait_state(4'h6, 20, "stall_reach_op_cal");
    repeat (80) @(negedge clk);
    check("stall_state", {60'h0, cur_state}, 64'h6);
    check("stall_err", {63'h0, err}, 64'h0);
    check("stall_irq", {63'h0, interrupt}, 64'h0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
